// File: rtl/macc4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : macc4_pkg
//  Description : Shared definitions for the macc4 sequencer CFU: the 3-bit
//                command opcodes and the sequencer FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package macc4_pkg;

    localparam logic [2:0] OP_SET_OFF  = 3'd0;
    localparam logic [2:0] OP_SET_ACC  = 3'd1;
    localparam logic [2:0] OP_PUSH_FLT = 3'd2;
    localparam logic [2:0] OP_PUSH_IN  = 3'd3;
    localparam logic [2:0] OP_RUN      = 3'd4;
    localparam logic [2:0] OP_GET_ACC  = 3'd5;
    localparam logic [2:0] OP_CLEAR    = 3'd6;
    localparam logic [2:0] OP_RSVD     = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage : macc4_pkg
`default_nettype wire

// File: rtl/macc4_lane.sv
`default_nettype none
// ============================================================================
//  Module      : macc4_lane
//  Description : Registered 4-lane int8 multiply-accumulate.
//                acc_out <= acc_in + sum_k f_k * (x_k + input_offset)
//                when en is high; all arithmetic is 32-bit and wraps.
//  Ports       : clk          - clock, rising edge
//                filt         - four signed int8 filter bytes
//                inp          - four signed int8 input bytes
//                input_offset - 32-bit offset added to every input byte
//                acc_in       - accumulator value to add onto
//                en           - load acc_out this cycle
//                acc_out      - registered accumulator result
//  Revision    : 1.0 - initial release
// ============================================================================
module macc4_lane (
    input  logic        clk,
    input  logic [31:0] filt,
    input  logic [31:0] inp,
    input  logic [31:0] input_offset,
    input  logic [31:0] acc_in,
    input  logic        en,
    output logic [31:0] acc_out
);

    logic [31:0] dot;

    // Bytes are sign-extended explicitly so the 32-bit products and sums are
    // plain modulo-2^32 arithmetic identical to two's complement.
    always_comb begin
        logic [31:0] f_ext;
        logic [31:0] x_ext;
        dot = 32'd0;
        for (int k = 0; k < 4; k++) begin
            f_ext = {{24{filt[8*k+7]}}, filt[8*k +: 8]};
            x_ext = {{24{inp[8*k+7]}},  inp[8*k +: 8]};
            dot   = dot + f_ext * (x_ext + input_offset);
        end
    end

    // No reset here: the owner clears the accumulator by pulsing en with a
    // zero filter and a zero acc_in.
    always_ff @(posedge clk) begin
        if (en) begin
            acc_out <= acc_in + dot;
        end
    end

endmodule : macc4_lane
`default_nettype wire

// File: rtl/macc4_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : macc4_sequencer
//  Description : Multi-cycle CFU running the 4-lane int8 MACC over two local
//                operand buffers (filter / input), one word per cycle.
//  Ports       : clk, reset (sync, active-low)
//                cmd_valid / cmd_ready, cmd_payload_function_id[2:0],
//                cmd_payload_inputs_0[31:0], cmd_payload_inputs_1[31:0]
//                rsp_valid / rsp_ready, rsp_payload_response_ok,
//                rsp_payload_outputs_0[31:0]
//  Revision    : 1.0 - initial release
// ============================================================================
module macc4_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_payload_response_ok,
    output logic [31:0] rsp_payload_outputs_0
);

    import macc4_pkg::*;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t      state;
    state_t      state_next;
    logic        ready;

    logic [31:0] fbuf [DEPTH];
    logic [31:0] ibuf [DEPTH];
    logic [AW:0] ffill;
    logic [AW:0] ifill;

    logic [31:0] offset;
    logic [31:0] acc;
    logic [31:0] out_q;
    logic        ok_q;
    logic        use_acc;

    logic [AW:0] run_n;
    logic [AW:0] rd_idx;
    logic        rd_valid;
    logic [31:0] fdata;
    logic [31:0] idata;

    logic        lane_en;
    logic [31:0] lane_filt;
    logic [31:0] lane_acc_in;

    logic        accept;
    logic [2:0]  op;
    logic [31:0] arg_a;
    logic [AW:0] arg_n;
    logic [AW:0] min_fill;
    logic        ffull;
    logic        ifull;
    logic        run_start;
    logic        run_done;

    assign accept    = cmd_valid & ready;
    assign op        = cmd_payload_function_id;
    assign arg_a     = cmd_payload_inputs_0;
    assign arg_n     = arg_a[AW:0];
    assign min_fill  = (ffill < ifill) ? ffill : ifill;
    assign ffull     = (ffill == FULL);
    assign ifull     = (ifill == FULL);
    assign run_start = accept && (op == OP_RUN) && (arg_n != '0) && (arg_n <= min_fill);
    // Last word is in the read register and gets accumulated this cycle.
    assign run_done  = (state == ST_RUN) && rd_valid && (rd_idx == run_n);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept)    state_next = run_start ? ST_RUN : ST_RESP;
            ST_RUN:  if (run_done)  state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // Registered ready keeps cmd_ready low while reset is held and makes it
    // rise only in the cycle after a response handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ready <= 1'b0;
        end else begin
            ready <= (state_next == ST_IDLE);
        end
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (!reset) begin
            offset   <= 32'd0;
            ffill    <= '0;
            ifill    <= '0;
            ok_q     <= 1'b1;
            out_q    <= 32'd0;
            use_acc  <= 1'b0;
            run_n    <= '0;
            rd_idx   <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (accept) begin
                ok_q    <= 1'b1;
                out_q   <= 32'd0;
                use_acc <= 1'b0;
                case (op)
                    OP_SET_OFF: begin
                        offset <= arg_a;
                        out_q  <= arg_a;
                    end
                    OP_SET_ACC: begin
                        out_q <= arg_a;
                    end
                    OP_PUSH_FLT: begin
                        if (ffull) begin
                            ok_q  <= 1'b0;
                            out_q <= {{(31-AW){1'b0}}, ffill};
                        end else begin
                            ffill <= ffill + 1'b1;
                            out_q <= {{(31-AW){1'b0}}, ffill + 1'b1};
                        end
                    end
                    OP_PUSH_IN: begin
                        if (ifull) begin
                            ok_q  <= 1'b0;
                            out_q <= {{(31-AW){1'b0}}, ifill};
                        end else begin
                            ifill <= ifill + 1'b1;
                            out_q <= {{(31-AW){1'b0}}, ifill + 1'b1};
                        end
                    end
                    OP_RUN: begin
                        // Result is the live accumulator once the run drains.
                        use_acc <= 1'b1;
                        ok_q    <= (arg_n <= min_fill);
                        run_n   <= arg_n;
                        rd_idx  <= '0;
                    end
                    OP_GET_ACC: begin
                        use_acc <= 1'b1;
                    end
                    OP_CLEAR: begin
                        ffill <= '0;
                        ifill <= '0;
                    end
                    default: ;
                endcase
            end

            if (state == ST_RUN) begin
                rd_valid <= (rd_idx != run_n);
                if (rd_idx != run_n) begin
                    rd_idx <= rd_idx + 1'b1;
                end
            end else begin
                rd_valid <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------- buffers
    always_ff @(posedge clk) begin
        if (reset && accept && (op == OP_PUSH_FLT) && !ffull) begin
            fbuf[ffill[AW-1:0]] <= arg_a;
        end
        if (reset && accept && (op == OP_PUSH_IN) && !ifull) begin
            ibuf[ifill[AW-1:0]] <= arg_a;
        end
    end

    always_ff @(posedge clk) begin
        fdata <= fbuf[rd_idx[AW-1:0]];
        idata <= ibuf[rd_idx[AW-1:0]];
    end

    // ------------------------------------------------------------- MAC lane
    // The lane register is the accumulator. Reset and SET_ACC load it by
    // feeding a zero filter word, so the dot product term vanishes.
    always_comb begin
        lane_en     = 1'b0;
        lane_filt   = fdata;
        lane_acc_in = acc;
        if (!reset) begin
            lane_en     = 1'b1;
            lane_filt   = 32'd0;
            lane_acc_in = 32'd0;
        end else if (accept && (op == OP_SET_ACC)) begin
            lane_en     = 1'b1;
            lane_filt   = 32'd0;
            lane_acc_in = arg_a;
        end else if ((state == ST_RUN) && rd_valid) begin
            lane_en     = 1'b1;
        end
    end

    macc4_lane u_lane (
        .clk          (clk),
        .filt         (lane_filt),
        .inp          (idata),
        .input_offset (offset),
        .acc_in       (lane_acc_in),
        .en           (lane_en),
        .acc_out      (acc)
    );

    // -------------------------------------------------------------- outputs
    assign cmd_ready               = ready;
    assign rsp_valid               = (state == ST_RESP);
    assign rsp_payload_response_ok = ok_q;
    assign rsp_payload_outputs_0   = use_acc ? acc : out_q;

endmodule : macc4_sequencer
`default_nettype wire

// File: tb/tb_macc4_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_macc4_sequencer
//  Description : Self-checking bench for macc4_sequencer. Table-driven command
//                vectors with a response scoreboard, plus hand-written reset,
//                overflow and backpressure sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_macc4_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam logic [2:0] OP_SET_OFF  = 3'd0;
    localparam logic [2:0] OP_SET_ACC  = 3'd1;
    localparam logic [2:0] OP_PUSH_FLT = 3'd2;
    localparam logic [2:0] OP_PUSH_IN  = 3'd3;
    localparam logic [2:0] OP_RUN      = 3'd4;
    localparam logic [2:0] OP_GET_ACC  = 3'd5;
    localparam logic [2:0] OP_CLEAR    = 3'd6;
    localparam logic [2:0] OP_RSVD     = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_payload_function_id = 3'd0;
    logic [31:0] cmd_payload_inputs_0 = 32'd0;
    logic [31:0] cmd_payload_inputs_1 = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_payload_response_ok;
    logic [31:0] rsp_payload_outputs_0;

    int total = 0;
    int bad   = 0;

    logic [32:0] exp_q [$];

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic        ok;
        logic [31:0] out;
        int          lat;
    } vec_t;

    vec_t tbl [$];

    always #5 clk = ~clk;

    macc4_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_response_ok (rsp_payload_response_ok),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Issue one command, then wait for and score its response.
    // lat < 0 skips the latency check; hold > 0 applies backpressure.
    task automatic send(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic ok, input logic [31:0] out, input int lat, input int hold);
        int          k;
        logic [32:0] e;
        logic [31:0] held;
        exp_q.push_back({ok, out});
        @(negedge clk);
        cmd_valid               = 1'b1;
        cmd_payload_function_id = op;
        cmd_payload_inputs_0    = a;
        cmd_payload_inputs_1    = $urandom;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            check({name, "_accept_timeout"}, 32'd0, 32'd1);
            cmd_valid = 1'b0;
            void'(exp_q.pop_front());
            return;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 1;
        while (!rsp_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!rsp_valid) begin
            check({name, "_rsp_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
            return;
        end
        if (lat >= 0) check({name, "_latency"}, k, lat);
        e = exp_q.pop_front();
        check({name, "_ok"},  {31'd0, rsp_payload_response_ok}, {31'd0, e[32]});
        check({name, "_out"}, rsp_payload_outputs_0, e[31:0]);
        if (hold > 0) begin
            held = rsp_payload_outputs_0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check({name, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
                check({name, "_hold_out"},   rsp_payload_outputs_0, held);
                check({name, "_hold_ready"}, {31'd0, cmd_ready}, 32'd0);
            end
        end
        rsp_ready = 1'b1;
        if (hold > 0) check({name, "_hs_cycle_ready"}, {31'd0, cmd_ready}, 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        if (hold > 0) begin
            check({name, "_post_hs_ready"}, {31'd0, cmd_ready}, 32'd1);
            check({name, "_post_hs_valid"}, {31'd0, rsp_valid}, 32'd0);
        end
    endtask

    task automatic add(input logic [2:0] op, input logic [31:0] a, input logic ok,
                       input logic [31:0] out, input int lat);
        tbl.push_back('{op: op, a: a, ok: ok, out: out, lat: lat});
    endtask

    initial begin
        int k;

        // -------- power-on reset
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("por_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("por_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("por_rsp_ok",    {31'd0, rsp_payload_response_ok}, 32'd1);
        check("por_rsp_out",   rsp_payload_outputs_0, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // -------- reset mid-RUN
        send("rst_setacc", OP_SET_ACC, 32'd55, 1'b1, 32'd55, 1, 0);
        for (int i = 0; i < 3; i++) begin
            send("rst_pf", OP_PUSH_FLT, 32'h01010101, 1'b1, i + 1, 1, 0);
            send("rst_pi", OP_PUSH_IN,  32'h01010101, 1'b1, i + 1, 1, 0);
        end
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_payload_function_id = OP_RUN;
        cmd_payload_inputs_0 = 32'd3;
        k = 0;
        while (!cmd_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check("rst_hold_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        end
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        send("rst_getacc", OP_GET_ACC, 32'd0, 1'b1, 32'd0, 1, 0);
        send("rst_pushin", OP_PUSH_IN, 32'h0, 1'b1, 32'd1, 1, 0);

        // -------- table-driven vectors
        add(OP_CLEAR,    32'd0,        1'b1, 32'd0,   1);
        add(OP_SET_OFF,  32'd0,        1'b1, 32'd0,   1);
        add(OP_SET_ACC,  32'd0,        1'b1, 32'd0,   1);
        add(OP_PUSH_FLT, 32'h02020202, 1'b1, 32'd1,   1);
        add(OP_PUSH_FLT, 32'h02020202, 1'b1, 32'd2,   1);
        add(OP_PUSH_FLT, 32'h02020202, 1'b1, 32'd3,   1);
        add(OP_PUSH_IN,  32'h03030303, 1'b1, 32'd1,   1);
        add(OP_PUSH_IN,  32'h03030303, 1'b1, 32'd2,   1);
        add(OP_PUSH_IN,  32'h03030303, 1'b1, 32'd3,   1);
        add(OP_RUN,      32'd3,        1'b1, 32'd72,  5);
        add(OP_GET_ACC,  32'd0,        1'b1, 32'd72,  1);
        add(OP_RUN,      32'd0,        1'b1, 32'd72,  1);
        add(OP_RUN,      32'd4,        1'b0, 32'd72,  1);
        add(OP_GET_ACC,  32'd0,        1'b1, 32'd72,  1);
        add(OP_RSVD,     32'h1234,     1'b1, 32'd0,   1);
        add(OP_GET_ACC,  32'd0,        1'b1, 32'd72,  1);
        add(OP_SET_OFF,  32'd1,        1'b1, 32'd1,   1);
        add(OP_RUN,      32'd3,        1'b1, 32'd168, 5);
        // offset and sign
        add(OP_CLEAR,    32'd0,        1'b1, 32'd0,   1);
        add(OP_SET_OFF,  32'd128,      1'b1, 32'd128, 1);
        add(OP_SET_ACC,  32'd0,        1'b1, 32'd0,   1);
        add(OP_PUSH_FLT, 32'h01FF7F80, 1'b1, 32'd1,   1);
        add(OP_PUSH_IN,  32'h80808080, 1'b1, 32'd1,   1);
        add(OP_RUN,      32'd1,        1'b1, 32'd0,   3);
        add(OP_SET_OFF,  32'd0,        1'b1, 32'd0,   1);
        add(OP_RUN,      32'd1,        1'b1, 32'd128, 3);
        // wrap and reuse
        add(OP_CLEAR,    32'd0,        1'b1, 32'd0,   1);
        add(OP_SET_ACC,  32'h7FFFFFFF, 1'b1, 32'h7FFFFFFF, 1);
        add(OP_PUSH_FLT, 32'h00000001, 1'b1, 32'd1,   1);
        add(OP_PUSH_IN,  32'h00000001, 1'b1, 32'd1,   1);
        add(OP_RUN,      32'd1,        1'b1, 32'h80000000, 3);
        add(OP_RUN,      32'd1,        1'b1, 32'h80000001, 3);

        foreach (tbl[i]) begin
            send($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].ok, tbl[i].out, tbl[i].lat, 0);
        end

        // -------- backpressure on a RUN response
        send("bp_run", OP_RUN, 32'd1, 1'b1, 32'h80000002, 3, 10);

        // -------- overflow
        send("ov_clear", OP_CLEAR, 32'd0, 1'b1, 32'd0, 1, 0);
        for (int i = 0; i <= DEPTH; i++) begin
            send($sformatf("ov_push%0d", i), OP_PUSH_IN, 32'(i), (i < DEPTH) ? 1'b1 : 1'b0,
                 (i < DEPTH) ? 32'(i + 1) : 32'(DEPTH), 1, 0);
        end

        // -------- underrun with ffill=2
        send("ur_pf0", OP_PUSH_FLT, 32'h11111111, 1'b1, 32'd1, 1, 0);
        send("ur_pf1", OP_PUSH_FLT, 32'h22222222, 1'b1, 32'd2, 1, 0);
        send("ur_run4", OP_RUN, 32'd4, 1'b0, 32'h80000002, 1, 0);
        send("ur_getacc", OP_GET_ACC, 32'd0, 1'b1, 32'h80000002, 1, 0);

        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule : tb_macc4_sequencer
`default_nettype wire
